// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: compares divided feedback period against the reference
// period each reference cycle and tracks lock with hysteresis counters.
module adpll_lock_detect #(
    parameter int CNT_W      = 16,
    parameter int ERR_TOL    = 64,
    parameter int CODE_TOL   = 1,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             fb_in,
    input  logic [3:0]       ctrl_code,
    output logic             locked,
    output logic             err_valid,
    output logic [CNT_W:0]   period_err,
    output logic             fb_missing
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {ACQUIRE, LOCKED} state_t;

    logic             ref_s1, ref_s2, ref_d, ref_edge;
    logic             fb_s1, fb_s2, fb_d, fb_edge;
    logic [CNT_W-1:0] ref_cnt, fb_cnt, fb_period;
    logic             fb_seen, ref_started;
    logic [1:0]       fb_edges;
    logic [3:0]       ctrl_prev;
    state_t           state, state_nx;
    logic [GW-1:0]    good_cnt, good_nx, good_inc;
    logic [BW-1:0]    bad_cnt, bad_nx, bad_inc;

    logic [CNT_W-1:0]        ref_per_now, fb_per_now, fb_period_eff;
    logic                    fb_seen_eff, fb_valid_eff, meas_fire, timeout, good;
    logic signed [CNT_W:0]   err_now;
    logic [CNT_W:0]          err_abs;
    logic [3:0]              code_delta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            {ref_s1, ref_s2, ref_d, ref_edge} <= '0;
            {fb_s1, fb_s2, fb_d, fb_edge}     <= '0;
        end else begin
            ref_s1   <= ref_in;
            ref_s2   <= ref_s1;
            ref_d    <= ref_s2;
            ref_edge <= ref_s2 & ~ref_d;
            fb_s1    <= fb_in;
            fb_s2    <= fb_s1;
            fb_d     <= fb_s2;
            fb_edge  <= fb_s2 & ~fb_d;
        end
    end

    always_comb begin
        ref_per_now   = (ref_cnt == CNT_MAX) ? CNT_MAX : ref_cnt + 1'b1;
        fb_per_now    = (fb_cnt == CNT_MAX) ? CNT_MAX : fb_cnt + 1'b1;
        // A coincident fb edge belongs to the window the ref edge closes.
        fb_period_eff = fb_edge ? fb_per_now : fb_period;
        fb_seen_eff   = fb_seen | fb_edge;
        fb_valid_eff  = (fb_edges == 2'd2) || (fb_edges == 2'd1 && fb_edge);
        meas_fire     = ref_edge & ref_started & fb_valid_eff;
        timeout       = (ref_cnt == CNT_MAX) & ~ref_edge;
        err_now       = $signed({1'b0, fb_period_eff}) - $signed({1'b0, ref_per_now});
        err_abs       = err_now[CNT_W] ? (~err_now + 1'b1) : err_now;
        code_delta    = (ctrl_code >= ctrl_prev) ? ctrl_code - ctrl_prev : ctrl_prev - ctrl_code;
        good          = (err_abs <= (CNT_W+1)'(ERR_TOL)) && (code_delta <= 4'(CODE_TOL)) &&
                        fb_seen_eff && (ref_per_now != CNT_MAX) && (fb_period_eff != CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_cnt     <= '0;
            fb_cnt      <= '0;
            fb_period   <= '0;
            fb_seen     <= 1'b0;
            fb_edges    <= '0;
            ref_started <= 1'b0;
            ctrl_prev   <= '0;
            err_valid   <= 1'b0;
            period_err  <= '0;
            fb_missing  <= 1'b0;
        end else begin
            if (ref_edge)                ref_cnt <= '0;
            else if (ref_cnt != CNT_MAX) ref_cnt <= ref_cnt + 1'b1;
            if (fb_edge) begin
                fb_cnt    <= '0;
                fb_period <= fb_per_now;
                if (fb_edges != 2'd2) fb_edges <= fb_edges + 1'b1;
            end else if (fb_cnt != CNT_MAX) begin
                fb_cnt <= fb_cnt + 1'b1;
            end
            if (ref_edge)     fb_seen <= 1'b0;
            else if (fb_edge) fb_seen <= 1'b1;
            if (timeout)       ref_started <= 1'b0;
            else if (ref_edge) ref_started <= 1'b1;
            // Sampled on every ref edge so the first measurement already has a baseline.
            if (ref_edge) ctrl_prev <= ctrl_code;
            err_valid <= meas_fire;
            if (meas_fire) begin
                period_err <= err_now;
                fb_missing <= ~fb_seen_eff;
            end
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        bad_nx   = bad_cnt;
        good_inc = (good_cnt == '1) ? good_cnt : good_cnt + 1'b1;
        bad_inc  = (bad_cnt == '1) ? bad_cnt : bad_cnt + 1'b1;
        if (timeout) begin
            state_nx = ACQUIRE;
            good_nx  = '0;
            bad_nx   = '0;
        end else if (meas_fire) begin
            case (state)
                ACQUIRE: begin
                    if (good) begin
                        good_nx = good_inc;
                        if (good_inc >= GW'(LOCK_CNT)) begin
                            state_nx = LOCKED;
                            bad_nx   = '0;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        bad_nx = bad_inc;
                        if (bad_inc >= BW'(UNLOCK_CNT)) begin
                            state_nx = ACQUIRE;
                            good_nx  = '0;
                        end
                    end else begin
                        bad_nx = '0;
                    end
                end
                default: state_nx = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            bad_cnt  <= bad_nx;
            locked   <= (state_nx == LOCKED);
        end
    end

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed bench for adpll_lock_detect: clean lock, tolerance edges, code jitter,
// missing feedback and lost reference.
module tb_adpll_lock_detect;
    localparam int CW = 12;

    logic          clk = 1'b0, reset = 1'b0, ref_in = 1'b0, fb_in = 1'b0;
    logic [3:0]    ctrl_code = 4'd0;
    logic          locked, err_valid, fb_missing;
    logic [CW:0]   period_err;

    int  n_chk = 0, n_bad = 0;
    int  ref_per = 1000, fb_per = 1000, epoch = 0;
    bit  ref_en = 1'b0, fb_en = 1'b0, tog = 1'b0;
    int  ref_ph = 0, fb_ph = 0, seen_epoch = 0, cyc = 0, last_ref = 0, n_ref = 0;
    int  ref_base, pe, mis, lk, lat, nv;

    adpll_lock_detect #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in), .ctrl_code(ctrl_code),
        .locked(locked), .err_valid(err_valid), .period_err(period_err), .fb_missing(fb_missing)
    );

    always #5 clk = ~clk;

    // Inputs change 2 ns after each rising clk edge; phases restart on a new epoch.
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            ref_ph = 0;
            fb_ph  = 0;
        end
        if (tog) begin
            ref_in = ~ref_in;
            fb_in  = ~fb_in;
        end else begin
            ref_in = ref_en && (ref_ph < ref_per / 2);
            if (ref_en && ref_ph == 0) begin
                last_ref = cyc;
                n_ref++;
            end
            ref_ph = (ref_ph >= ref_per - 1) ? 0 : ref_ph + 1;
            fb_in  = fb_en && (fb_ph < fb_per / 2);
            fb_ph  = (fb_ph >= fb_per - 1) ? 0 : fb_ph + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic restart(input int rp, input int fp, input logic [3:0] code);
        ref_en = 1'b0;
        fb_en  = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        ref_per   = rp;
        fb_per    = fp;
        ctrl_code = code;
        ref_base  = n_ref;
        epoch++;
        ref_en = 1'b1;
        fb_en  = 1'b1;
    endtask

    task automatic wait_meas(input int budget, output int o_pe, output int o_mis,
                             output int o_lk, output int o_lat);
        int got;
        got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            @(negedge clk);
            if (err_valid) got = 1;
        end
        chk("meas_seen", got, 1);
        o_pe  = int'($signed(period_err));
        o_mis = int'(fb_missing);
        o_lk  = int'(locked);
        o_lat = cyc - last_ref;
    endtask

    initial begin
        // reset with toggling inputs
        tog = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_period_err", int'(period_err), 0);
        chk("rst_fb_missing", int'(fb_missing), 0);
        tog = 1'b0;
        repeat (2) @(negedge clk);

        // clean lock, coincident ref/fb edges
        restart(2000, 2000, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            wait_meas(4100, pe, mis, lk, lat);
            if (i == 1) chk("first_meas_ref_edges", n_ref - ref_base, 2);
            chk("clean_err", pe, 0);
            chk("clean_missing", mis, 0);
            chk("clean_locked", lk, int'(i == 8));
            if (i == 8) chk("lock_latency", lat, 4);
        end

        // +64: good, locks on 8th measurement
        restart(1000, 1064, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            wait_meas(2100, pe, mis, lk, lat);
            chk("tol64_err", pe, 64);
            chk("tol64_locked", lk, int'(i == 8));
        end

        // +65: bad, never locks
        restart(1000, 1065, 4'd8);
        for (int i = 1; i <= 9; i++) begin
            wait_meas(2100, pe, mis, lk, lat);
            chk("tol65_err", pe, 65);
            chk("tol65_locked", lk, 0);
        end

        // -65: negative error sign-extended
        restart(1000, 935, 4'd8);
        for (int i = 1; i <= 2; i++) begin
            wait_meas(2100, pe, mis, lk, lat);
            chk("neg65_err", pe, -65);
            chk("neg65_raw", int'(period_err), 8192 - 65);
            chk("neg65_missing", mis, 0);
        end

        // code jitter: steps of 1 keep lock, steps of 2 drop it after four periods
        restart(1000, 1000, 4'd8);
        for (int i = 1; i <= 8; i++) wait_meas(2100, pe, mis, lk, lat);
        chk("jit_pre_locked", lk, 1);
        ctrl_code = 4'd9;
        wait_meas(2100, pe, mis, lk, lat);
        chk("step1_up_locked", lk, 1);
        ctrl_code = 4'd8;
        wait_meas(2100, pe, mis, lk, lat);
        chk("step1_down_locked", lk, 1);
        for (int j = 0; j < 4; j++) begin
            ctrl_code = (j % 2 == 0) ? 4'd10 : 4'd8;
            wait_meas(2100, pe, mis, lk, lat);
            chk("jit_err", pe, 0);
            chk("jit_locked", lk, int'(j < 3));
        end

        // missing feedback then restore
        restart(1000, 1000, 4'd8);
        for (int i = 1; i <= 8; i++) wait_meas(2100, pe, mis, lk, lat);
        chk("miss_pre_locked", lk, 1);
        fb_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_meas(2100, pe, mis, lk, lat);
            chk("miss_flag", mis, 1);
            chk("miss_locked", lk, int'(j < 3));
        end
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!ref_in) break;
        end
        fb_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            wait_meas(2100, pe, mis, lk, lat);
            if (i == 1) chk("restore_missing", mis, 0);
            if (i >= 8) chk("relock_locked", lk, int'(i == 9));
        end

        // lost reference: unlock once ref counter saturates, no measurements
        ref_en = 1'b0;
        nv = 0;
        repeat (3000) begin
            @(negedge clk);
            if (err_valid) nv++;
        end
        chk("noref_still_locked", int'(locked), 1);
        repeat (1200) begin
            @(negedge clk);
            if (err_valid) nv++;
        end
        chk("noref_unlocked", int'(locked), 0);
        chk("noref_no_meas", nv, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/adpll_lock_detect.md
Name: adpll_lock_detect

Overview:
- Monitors the ADPLL loop and asserts `locked` once the divided feedback clock matches the reference frequency and the loop-filter control code has settled.
- Sits downstream of the divide-by-4 feedback divider and the loop filter.
- Consumes the reference clock, the divided feedback clock and the 4-bit VCO control word. Produces a lock flag and a per-reference-period frequency-error report for the top level and debug pins.
- All logic runs on the 50 MHz system clock; `ref_in` and `fb_in` are treated as asynchronous inputs.

Parameters:
- CNT_W, 16, width of the period counters in clk cycles (covers 20000 cycles = 2.5 kHz at 50 MHz).
- ERR_TOL, 64, maximum |fb_period - ref_period| in clk cycles for a good measurement.
- CODE_TOL, 1, maximum |ctrl_code change| between consecutive reference periods for a good measurement.
- LOCK_CNT, 8, consecutive good measurements required to enter LOCKED.
- UNLOCK_CNT, 4, consecutive bad measurements required to leave LOCKED.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous, active-low.
- ref_in, input, 1, reference clock, asynchronous.
- fb_in, input, 1, divided feedback clock, asynchronous.
- ctrl_code, input, 4, VCO control word from the loop filter, unsigned.
- locked, output, 1, lock indicator, registered.
- err_valid, output, 1, one-cycle pulse when a new period_err is available.
- period_err, output, CNT_W+1, signed fb_period minus ref_period, held until the next err_valid.
- fb_missing, output, 1, set when the last reference period contained no fb rising edge.

Behaviour:
- **Reset** (reset=0 at a clk edge):
  - locked=0, err_valid=0, period_err=0, fb_missing=0.
  - All counters, synchronisers and history registers cleared; FSM enters ACQUIRE.
  - Reset mid-operation discards any partial measurement.
- **Input synchronisation:**
  - ref_in and fb_in each pass through a 2-FF synchroniser, then a registered rising-edge detector.
  - An input edge is therefore seen 3 clk cycles after it occurs.
- **Reference counter:**
  - ref_cnt increments every cycle and saturates at 2^CNT_W-1.
  - On a ref edge: ref_period <= ref_cnt+1 and ref_cnt <= 0.
- **Feedback counter:**
  - fb_cnt behaves the same way on fb edges, loading fb_period.
  - fb_seen is set on any fb edge and cleared on each ref edge.
- **Qualification:**
  - The first ref edge after reset only starts the measurement; no err_valid is produced.
  - err_valid also requires that at least two fb edges have occurred since reset; otherwise fb_period is invalid and the sample is skipped.
- **Simultaneous ref and fb edges in the same cycle:** the fb edge is applied first. Its fb_period update and fb_seen=1 count toward the measurement closed by that ref edge.
- **Measurement** (registered, 1 cycle after the ref edge):
  - period_err = fb_period - ref_period, sign-extended to CNT_W+1.
  - err_valid pulses for that cycle.
  - fb_missing <= ~fb_seen (value before clearing).
  - code_delta = |ctrl_code - ctrl_prev|, where ctrl_prev is ctrl_code sampled at the previous qualified ref edge.
- **good** = |period_err| <= ERR_TOL AND code_delta <= CODE_TOL AND fb_seen AND neither period saturated. Otherwise the sample is bad.
- **FSM** (updates on the err_valid cycle; locked changes that same cycle):
  - ACQUIRE:
    - good: good_cnt++.
    - bad: good_cnt <= 0.
    - When good_cnt reaches LOCK_CNT: go to LOCKED, locked=1, bad_cnt <= 0.
  - LOCKED:
    - bad: bad_cnt++.
    - good: bad_cnt <= 0.
    - When bad_cnt reaches UNLOCK_CNT: go to ACQUIRE, locked=0, good_cnt <= 0.
  - good_cnt and bad_cnt saturate and never wrap.
- **Timeout:** if ref_cnt saturates (no reference), locked is forced to 0 on the next clk and the FSM returns to ACQUIRE. Measurements resume on the next ref edge, which restarts qualification.
- **Control code:** ctrl_code is unsigned 0..15; the difference has no wrap (15 to 0 gives delta 15).

Test Plan:
- **Reset:** hold reset=0 for 5 cycles with ref/fb toggling -> locked=0, err_valid=0, period_err=0, fb_missing=0. First err_valid appears only after the second ref edge.
- **Clean lock:** ref period 2000 cycles, fb period 2000 cycles, ctrl_code constant 8 -> period_err=0 on every err_valid; locked rises on the 8th err_valid, 4 cycles after that ref input edge.
- **Tolerance edge:**
  - fb period 2064 -> period_err=+64, counted good, locks.
  - fb period 2065 -> period_err=+65, never locks.
  - fb period 1935 -> period_err=-65, negative value correctly sign-extended.
- **Code jitter:** locked loop, ctrl_code steps 8->10 for 4 consecutive periods -> 4 bad samples, locked falls on the 4th err_valid. Steps of 8->9 keep lock.
- **Missing feedback:** locked loop, fb_in held low -> fb_missing=1 on each err_valid; locked drops after 4 periods. Restore fb -> relock after 8 good samples.
- **Coincident edges and lost ref:**
  - ref and fb edges in the same cycle -> fb edge counted (fb_missing=0).
  - Stop ref_in -> locked=0 once ref_cnt saturates (65535 cycles), no err_valid.
